// File: rtl/parser_sched_pkg.sv
// Shared constants and helpers for the parser lane scheduler and its lane slots.
`ifndef PARSER_SCHED_PKG_SV
`define PARSER_SCHED_PKG_SV

// Selects lane idx's PKT_HDR_LEN-wide slice out of a packed per-lane bus.
`define PSCHED_LANE_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package parser_sched_pkg;

    localparam int ERR_CNT_WIDTH = 16;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

    // Round-robin pointer step; wraps after the last lane, which need not be a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned num_lanes);
        return (ptr >= num_lanes - 1) ? 0 : ptr + 1;
    endfunction

endpackage

`endif

// File: rtl/parser_lane_slot.sv
// Per-lane bookkeeping: occupancy, a one-deep PHV hold register and result error detection.
module parser_lane_slot #(
    parameter int PKT_HDR_LEN = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dispatch,
    input  logic                   release_hold,
    input  logic                   hdr_valid,
    input  logic [PKT_HDR_LEN-1:0] hdr_in,
    output logic                   busy,
    output logic                   hold_v,
    output logic [PKT_HDR_LEN-1:0] hold,
    output logic                   err
);
    logic                   busy_q, busy_d;
    logic                   hold_v_q, hold_v_d;
    logic [PKT_HDR_LEN-1:0] hold_q, hold_d;
    logic                   capture;

    // A result is only accepted from a lane that owns a packet and has not yet returned it.
    // Release and capture never coincide: release needs a full hold, capture an empty one.
    always_comb begin
        capture  = hdr_valid & busy_q & ~hold_v_q;
        err      = hdr_valid & ~capture;
        busy_d   = busy_q;
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        if (release_hold) begin
            busy_d   = 1'b0;
            hold_v_d = 1'b0;
        end
        if (dispatch) begin
            busy_d = 1'b1;
        end
        if (capture) begin
            hold_v_d = 1'b1;
            hold_d   = hdr_in;
        end
    end

    // Control flags; reset discards any in-flight packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            hold_v_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            hold_v_q <= hold_v_d;
        end
    end

    // PHV data is qualified by hold_v, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign busy   = busy_q;
    assign hold_v = hold_v_q;
    assign hold   = hold_q;

endmodule

// File: rtl/parser_lane_scheduler.sv
// Round-robin dispatch of packets to parser lanes, config-word routing, and in-order PHV collection.
module parser_lane_scheduler
    import parser_sched_pkg::*;
#(
    parameter int C_NUM_LANES      = 4,
    parameter int C_LANE_IDX_WIDTH = 2,
    parameter int PKT_HDR_LEN      = 1024,
    parameter int C_CNT_WIDTH      = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               segs_in_valid,
    output logic                               segs_in_ready,
    input  logic                               bram_in_valid,
    output logic [C_NUM_LANES-1:0]             lane_segs_valid,
    output logic [C_NUM_LANES-1:0]             lane_bram_valid,
    input  logic [C_NUM_LANES*PKT_HDR_LEN-1:0] lane_hdr_in,
    input  logic [C_NUM_LANES-1:0]             lane_hdr_valid,
    output logic [PKT_HDR_LEN-1:0]             pkt_hdr_vec,
    output logic                               parser_valid,
    input  logic                               stg_ready,
    output logic [C_CNT_WIDTH-1:0]             outstanding,
    output logic [ERR_CNT_WIDTH-1:0]           err_cnt
);
    logic [C_LANE_IDX_WIDTH-1:0] disp_ptr_q, disp_ptr_d;
    logic [C_LANE_IDX_WIDTH-1:0] cfg_ptr_q, cfg_ptr_d;
    logic [C_LANE_IDX_WIDTH-1:0] out_ptr_q, out_ptr_d;
    logic [C_CNT_WIDTH-1:0]      cfg_cnt_q, cfg_cnt_d;
    logic [C_CNT_WIDTH-1:0]      outstanding_q, outstanding_d;
    logic [ERR_CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic [PKT_HDR_LEN-1:0]      pkt_hdr_vec_q, pkt_hdr_vec_d;
    logic                        parser_valid_q, parser_valid_d;

    logic [C_NUM_LANES-1:0]             lane_busy, lane_hold_v, lane_err, lane_release;
    logic [C_NUM_LANES*PKT_HDR_LEN-1:0] lane_hold;
    logic                               dispatch, cfg_take, cfg_drop, emit;
    logic [31:0]                        err_sum, err_total;

    assign segs_in_ready = ~lane_busy[disp_ptr_q];
    assign dispatch      = segs_in_valid & segs_in_ready & ~reset;

    // Dispatch and config routing. cfg_ptr trails disp_ptr by cfg_cnt, so with cfg_cnt=0 a
    // same-cycle config word lands on the lane being dispatched right now.
    always_comb begin
        lane_segs_valid = '0;
        lane_bram_valid = '0;
        disp_ptr_d      = disp_ptr_q;
        cfg_ptr_d       = cfg_ptr_q;
        cfg_cnt_d       = cfg_cnt_q;
        cfg_take        = bram_in_valid & ~reset & ((cfg_cnt_q != '0) | dispatch);
        cfg_drop        = bram_in_valid & ~reset & ~cfg_take;
        if (dispatch) begin
            lane_segs_valid[disp_ptr_q] = 1'b1;
            disp_ptr_d = C_LANE_IDX_WIDTH'(ptr_inc(32'(disp_ptr_q), C_NUM_LANES));
        end
        if (cfg_take) begin
            lane_bram_valid[cfg_ptr_q] = 1'b1;
            cfg_ptr_d = C_LANE_IDX_WIDTH'(ptr_inc(32'(cfg_ptr_q), C_NUM_LANES));
        end
        if (dispatch && !cfg_take) begin
            cfg_cnt_d = cfg_cnt_q + C_CNT_WIDTH'(1);
        end else if (!dispatch && cfg_take) begin
            cfg_cnt_d = cfg_cnt_q - C_CNT_WIDTH'(1);
        end
    end

    // In-order emission: only the lane at out_ptr may load the output register.
    always_comb begin
        emit           = lane_hold_v[out_ptr_q] & (~parser_valid_q | stg_ready);
        pkt_hdr_vec_d  = pkt_hdr_vec_q;
        parser_valid_d = parser_valid_q;
        out_ptr_d      = out_ptr_q;
        lane_release   = '0;
        outstanding_d  = outstanding_q;
        if (emit) begin
            pkt_hdr_vec_d           = `PSCHED_LANE_SLICE(lane_hold, out_ptr_q, PKT_HDR_LEN);
            parser_valid_d          = 1'b1;
            out_ptr_d               = C_LANE_IDX_WIDTH'(ptr_inc(32'(out_ptr_q), C_NUM_LANES));
            lane_release[out_ptr_q] = 1'b1;
        end else if (stg_ready) begin
            parser_valid_d = 1'b0;
        end
        if (dispatch && !emit) begin
            outstanding_d = outstanding_q + C_CNT_WIDTH'(1);
        end else if (!dispatch && emit) begin
            outstanding_d = outstanding_q - C_CNT_WIDTH'(1);
        end
    end

    // Error accumulation: every violation in a cycle counts, clamped at the counter maximum.
    always_comb begin
        err_sum = 32'(cfg_drop);
        for (int i = 0; i < C_NUM_LANES; i++) begin
            err_sum = err_sum + 32'(lane_err[i]);
        end
        err_total = 32'(err_cnt_q) + err_sum;
        err_cnt_d = (err_total > 32'(ERR_CNT_MAX)) ? ERR_CNT_MAX : ERR_CNT_WIDTH'(err_total);
    end

    // Pointers, counters and the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_ptr_q     <= '0;
            cfg_ptr_q      <= '0;
            out_ptr_q      <= '0;
            cfg_cnt_q      <= '0;
            outstanding_q  <= '0;
            err_cnt_q      <= '0;
            pkt_hdr_vec_q  <= '0;
            parser_valid_q <= 1'b0;
        end else begin
            disp_ptr_q     <= disp_ptr_d;
            cfg_ptr_q      <= cfg_ptr_d;
            out_ptr_q      <= out_ptr_d;
            cfg_cnt_q      <= cfg_cnt_d;
            outstanding_q  <= outstanding_d;
            err_cnt_q      <= err_cnt_d;
            pkt_hdr_vec_q  <= pkt_hdr_vec_d;
            parser_valid_q <= parser_valid_d;
        end
    end

    for (genvar i = 0; i < C_NUM_LANES; i++) begin : g_slot
        parser_lane_slot #(
            .PKT_HDR_LEN(PKT_HDR_LEN)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .dispatch    (lane_segs_valid[i]),
            .release_hold(lane_release[i]),
            .hdr_valid   (lane_hdr_valid[i]),
            .hdr_in      (`PSCHED_LANE_SLICE(lane_hdr_in, i, PKT_HDR_LEN)),
            .busy        (lane_busy[i]),
            .hold_v      (lane_hold_v[i]),
            .hold        (`PSCHED_LANE_SLICE(lane_hold, i, PKT_HDR_LEN)),
            .err         (lane_err[i])
        );
    end

    assign pkt_hdr_vec  = pkt_hdr_vec_q;
    assign parser_valid = parser_valid_q;
    assign outstanding  = outstanding_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_parser_lane_scheduler.sv
// Directed bench: a 4-lane instance for dispatch/ordering/backpressure/errors/reset and a
// 3-lane instance for pointer wrap. Inputs change on the falling edge, outputs are read there too.
module tb_parser_lane_scheduler;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic           segs_in_valid, segs_in_ready, bram_in_valid, parser_valid, stg_ready;
    logic [3:0]     lane_segs_valid, lane_bram_valid, lane_hdr_valid;
    logic [4*W-1:0] lane_hdr_in;
    logic [W-1:0]   pkt_hdr_vec;
    logic [2:0]     outstanding;
    logic [15:0]    err_cnt;

    logic           segs_in_valid_3, segs_in_ready_3, bram_in_valid_3, parser_valid_3, stg_ready_3;
    logic [2:0]     lane_segs_valid_3, lane_bram_valid_3, lane_hdr_valid_3;
    logic [3*W-1:0] lane_hdr_in_3;
    logic [W-1:0]   pkt_hdr_vec_3;
    logic [1:0]     outstanding_3;
    logic [15:0]    err_cnt_3;

    int n_chk;
    int n_err;

    parser_lane_scheduler #(
        .C_NUM_LANES(4), .C_LANE_IDX_WIDTH(2), .PKT_HDR_LEN(W), .C_CNT_WIDTH(3)
    ) dut (
        .clk(clk), .reset(reset),
        .segs_in_valid(segs_in_valid), .segs_in_ready(segs_in_ready),
        .bram_in_valid(bram_in_valid),
        .lane_segs_valid(lane_segs_valid), .lane_bram_valid(lane_bram_valid),
        .lane_hdr_in(lane_hdr_in), .lane_hdr_valid(lane_hdr_valid),
        .pkt_hdr_vec(pkt_hdr_vec), .parser_valid(parser_valid), .stg_ready(stg_ready),
        .outstanding(outstanding), .err_cnt(err_cnt)
    );

    parser_lane_scheduler #(
        .C_NUM_LANES(3), .C_LANE_IDX_WIDTH(2), .PKT_HDR_LEN(W), .C_CNT_WIDTH(2)
    ) dut3 (
        .clk(clk), .reset(reset),
        .segs_in_valid(segs_in_valid_3), .segs_in_ready(segs_in_ready_3),
        .bram_in_valid(bram_in_valid_3),
        .lane_segs_valid(lane_segs_valid_3), .lane_bram_valid(lane_bram_valid_3),
        .lane_hdr_in(lane_hdr_in_3), .lane_hdr_valid(lane_hdr_valid_3),
        .pkt_hdr_vec(pkt_hdr_vec_3), .parser_valid(parser_valid_3), .stg_ready(stg_ready_3),
        .outstanding(outstanding_3), .err_cnt(err_cnt_3)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        segs_in_valid = 1'b1; bram_in_valid = 1'b0; lane_hdr_valid = '0; lane_hdr_in = '0; stg_ready = 1'b1;
        segs_in_valid_3 = 1'b0; bram_in_valid_3 = 1'b0; lane_hdr_valid_3 = '0; lane_hdr_in_3 = '0;
        stg_ready_3 = 1'b1;

        // reset state
        @(negedge clk); @(negedge clk); #1;
        check("rst_strobe_gated", lane_segs_valid, 4'b0000);
        segs_in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rst_parser_valid", parser_valid, 1'b0);
        check("rst_phv", pkt_hdr_vec, 64'h0);
        check("rst_outstanding", outstanding, 3'd0);
        check("rst_err_cnt", err_cnt, 16'h0);
        check("rst_segs_ready", segs_in_ready, 1'b1);

        // smoke: 4 back-to-back dispatches with paired config words
        for (int i = 0; i < 4; i++) begin
            segs_in_valid = 1'b1; bram_in_valid = 1'b1; #1;
            check("smoke_disp", lane_segs_valid, 4'b0001 << i);
            check("smoke_cfg", lane_bram_valid, 4'b0001 << i);
            @(negedge clk);
        end
        segs_in_valid = 1'b0; bram_in_valid = 1'b0;
        check("smoke_outstanding", outstanding, 3'd4);
        check("smoke_all_busy", segs_in_ready, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                check("smoke_valid", parser_valid, 1'b1);
                check("smoke_phv", pkt_hdr_vec, 64'hA + 64'(i - 2));
            end
            lane_hdr_valid = '0;
            if (i < 4) begin
                lane_hdr_valid[i] = 1'b1;
                lane_hdr_in[i*W +: W] = 64'hA + 64'(i);
            end
            @(negedge clk);
        end
        check("smoke_idle_valid", parser_valid, 1'b0);
        check("smoke_drained", outstanding, 3'd0);

        // reordering: lane 1 finishes before lane 0
        segs_in_valid = 1'b1; bram_in_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        segs_in_valid = 1'b0; bram_in_valid = 1'b0;
        lane_hdr_valid = 4'b0010; lane_hdr_in[1*W +: W] = 64'h11;
        @(negedge clk);
        check("reord_lane1_held", parser_valid, 1'b0);
        lane_hdr_valid = 4'b0001; lane_hdr_in[0*W +: W] = 64'h10;
        @(negedge clk);
        lane_hdr_valid = '0;
        check("reord_wait", parser_valid, 1'b0);
        @(negedge clk);
        check("reord_first_valid", parser_valid, 1'b1);
        check("reord_first", pkt_hdr_vec, 64'h10);
        @(negedge clk);
        check("reord_second", pkt_hdr_vec, 64'h11);
        @(negedge clk);
        check("reord_idle", parser_valid, 1'b0);
        check("reord_drained", outstanding, 3'd0);

        // backpressure: 20 stalled cycles, only four lanes can be filled
        stg_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            segs_in_valid = 1'b1; bram_in_valid = (c < 4); #1;
            check("bp_disp", lane_segs_valid, (c < 4) ? (4'b0001 << ((2 + c) % 4)) : 4'b0000);
            @(negedge clk);
        end
        segs_in_valid = 1'b0; bram_in_valid = 1'b0;
        check("bp_ready_low", segs_in_ready, 1'b0);
        check("bp_outstanding", outstanding, 3'd4);
        check("bp_phv_stable", pkt_hdr_vec, 64'h11);
        check("bp_valid_low", parser_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            lane_hdr_valid = '0;
            lane_hdr_valid[(2 + k) % 4] = 1'b1;
            lane_hdr_in[((2 + k) % 4)*W +: W] = 64'h20 + 64'(k);
            @(negedge clk);
        end
        lane_hdr_valid = '0;
        check("bp_head_valid", parser_valid, 1'b1);
        check("bp_head_phv", pkt_hdr_vec, 64'h20);
        check("bp_head_outstanding", outstanding, 3'd3);
        check("bp_lane_freed", segs_in_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("bp_hold_phv", pkt_hdr_vec, 64'h20);
        check("bp_hold_valid", parser_valid, 1'b1);
        stg_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("bp_release_valid", parser_valid, 1'b1);
            check("bp_release_phv", pkt_hdr_vec, 64'h20 + 64'(k));
        end
        @(negedge clk);
        check("bp_release_idle", parser_valid, 1'b0);
        check("bp_release_drained", outstanding, 3'd0);
        segs_in_valid = 1'b1; bram_in_valid = 1'b1; #1;
        check("bp_late_disp0", lane_segs_valid, 4'b0100);
        @(negedge clk); #1;
        check("bp_late_disp1", lane_segs_valid, 4'b1000);
        @(negedge clk);
        segs_in_valid = 1'b0; bram_in_valid = 1'b0;
        check("bp_late_outstanding", outstanding, 3'd2);
        lane_hdr_valid = 4'b1100; lane_hdr_in[2*W +: W] = 64'h30; lane_hdr_in[3*W +: W] = 64'h31;
        @(negedge clk);
        lane_hdr_valid = '0;
        check("multi_cap_wait", parser_valid, 1'b0);
        @(negedge clk);
        check("multi_cap_first", pkt_hdr_vec, 64'h30);
        @(negedge clk);
        check("multi_cap_second", pkt_hdr_vec, 64'h31);
        @(negedge clk);
        check("multi_cap_drained", outstanding, 3'd0);

        // protocol errors
        bram_in_valid = 1'b1; #1;
        check("err_bram_not_routed", lane_bram_valid, 4'b0000);
        @(negedge clk);
        bram_in_valid = 1'b0;
        check("err_bram_drop", err_cnt, 16'd1);
        lane_hdr_valid = 4'b0001;
        @(negedge clk);
        lane_hdr_valid = '0;
        check("err_idle_lane", err_cnt, 16'd2);
        bram_in_valid = 1'b1; lane_hdr_valid = 4'b0010;
        @(negedge clk);
        bram_in_valid = 1'b0; lane_hdr_valid = '0;
        check("err_double", err_cnt, 16'd4);

        // config word arriving a cycle after its dispatch
        segs_in_valid = 1'b1; #1;
        check("cfg_disp", lane_segs_valid, 4'b0001);
        @(negedge clk);
        segs_in_valid = 1'b0; bram_in_valid = 1'b1; #1;
        check("cfg_late_route", lane_bram_valid, 4'b0001);
        @(negedge clk);
        bram_in_valid = 1'b0; lane_hdr_valid = 4'b0001; lane_hdr_in[0*W +: W] = 64'h40;
        @(negedge clk);
        lane_hdr_valid = '0;
        @(negedge clk);
        check("cfg_phv", pkt_hdr_vec, 64'h40);
        check("cfg_no_err", err_cnt, 16'd4);
        @(negedge clk);

        // saturation: five errors per cycle from 4 up to 0xFFFE, then past the top
        bram_in_valid = 1'b1; lane_hdr_valid = 4'hF;
        repeat (13106) @(negedge clk);
        check("err_near_sat", err_cnt, 16'hFFFE);
        lane_hdr_valid = 4'b0001;
        @(negedge clk);
        check("err_sat", err_cnt, 16'hFFFF);
        lane_hdr_valid = 4'hF;
        @(negedge clk);
        bram_in_valid = 1'b0; lane_hdr_valid = '0;
        check("err_sat_hold", err_cnt, 16'hFFFF);

        // reset mid-operation with packets in flight and a PHV on the output
        segs_in_valid = 1'b1; bram_in_valid = 1'b1;
        repeat (4) @(negedge clk);
        segs_in_valid = 1'b0; bram_in_valid = 1'b0;
        stg_ready = 1'b0;
        lane_hdr_valid = 4'b0010; lane_hdr_in[1*W +: W] = 64'h60;
        @(negedge clk);
        lane_hdr_valid = '0;
        @(negedge clk);
        check("rst_pre_valid", parser_valid, 1'b1);
        check("rst_pre_phv", pkt_hdr_vec, 64'h60);
        check("rst_pre_outstanding", outstanding, 3'd3);
        reset = 1'b1; segs_in_valid = 1'b1; #1;
        check("rst_mid_strobe_gated", lane_segs_valid, 4'b0000);
        @(negedge clk);
        reset = 1'b0; segs_in_valid = 1'b0;
        check("rst_mid_valid", parser_valid, 1'b0);
        check("rst_mid_outstanding", outstanding, 3'd0);
        check("rst_mid_ready", segs_in_ready, 1'b1);
        check("rst_mid_phv", pkt_hdr_vec, 64'h0);
        check("rst_mid_err", err_cnt, 16'h0);
        segs_in_valid = 1'b1; #1;
        check("rst_mid_lane0", lane_segs_valid, 4'b0001);
        @(negedge clk);
        segs_in_valid = 1'b0; stg_ready = 1'b1;

        // wrap on the 3-lane instance: 7 packets, each lane answers one cycle after dispatch
        for (int i = 0; i < 10; i++) begin
            if (i >= 3) begin
                check("wrap_valid", parser_valid_3, 1'b1);
                check("wrap_phv", pkt_hdr_vec_3, 64'h50 + 64'(i - 3));
            end
            segs_in_valid_3 = (i < 7);
            bram_in_valid_3 = (i < 7);
            lane_hdr_valid_3 = '0;
            if (i >= 1 && i <= 7) begin
                lane_hdr_valid_3[(i - 1) % 3] = 1'b1;
                lane_hdr_in_3[((i - 1) % 3)*W +: W] = 64'h50 + 64'(i - 1);
            end
            #1;
            if (i < 7) begin
                check("wrap_disp", lane_segs_valid_3, 3'b001 << (i % 3));
                check("wrap_cfg", lane_bram_valid_3, 3'b001 << (i % 3));
            end
            @(negedge clk);
        end
        check("wrap_idle", parser_valid_3, 1'b0);
        check("wrap_drained", outstanding_3, 2'd0);
        check("wrap_ready", segs_in_ready_3, 1'b1);
        check("wrap_no_err", err_cnt_3, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
